median_window_sequencer: RTL and testbench

//  Raster sequencer for the 5x5 median path. Sits beside the pixel receiver and tracks the input raster position.
//  It flags when the kernel window around each centre pixel is complete, and marks border centres for bypass.
//  At frame end it throttles the input and drives flush pushes, so the last rows drain out of the line buffers.
//  It also produces SOF/EOL/EOF markers aligned to window centres for the transmitter.

---
 rtl/median_window_sequencer.sv | 150 +++++++++++++++
 tb/tb_median_window_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/median_window_sequencer.sv
// median_window_sequencer: raster position tracker for the 5x5 median path; emits window
// centres with border/SOF/EOL/EOF tags and drives flush pushes to drain the last rows.
module median_window_sequencer #(
    parameter int IMG_WIDTH   = 4096,
    parameter int IMG_HEIGHT  = 3072,
    parameter int KERNEL_SIZE = 5,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_aresetn,
    input  logic          i_pix_valid,
    input  logic          i_sof,
    input  logic          i_eol,
    output logic          o_in_ready,
    output logic          o_flush_push,
    output logic          o_ctr_valid,
    output logic [XW-1:0] o_ctr_x,
    output logic [YW-1:0] o_ctr_y,
    output logic          o_ctr_border,
    output logic          o_ctr_sof,
    output logic          o_ctr_eol,
    output logic          o_ctr_eof,
    output logic          o_busy,
    output logic          o_err
);
    localparam int HALF = (KERNEL_SIZE - 1) / 2;
    localparam int LAG  = HALF * IMG_WIDTH + HALF;
    localparam int FW   = $clog2(LAG + 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_LO  = XW'(HALF);
    localparam logic [XW-1:0] X_HI  = XW'(IMG_WIDTH - HALF);
    localparam logic [YW-1:0] Y_LO  = YW'(HALF);
    localparam logic [YW-1:0] Y_HI  = YW'(IMG_HEIGHT - HALF);
    localparam logic [FW-1:0] F_LAG = FW'(LAG);

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [XW-1:0] in_x_q, in_x_d, ctr_x_q, ctr_x_d, cx_q, cx_d, pos_x;
    logic [YW-1:0] in_y_q, in_y_d, ctr_y_q, ctr_y_d, cy_q, cy_d, pos_y;
    logic [FW-1:0] fill_q, fill_d;
    logic          err_q, err_d, vld_q, vld_d, bdr_q, bdr_d;
    logic          csof_q, csof_d, ceol_q, ceol_d, ceof_q, ceof_d;
    logic          accept, start, take, last_x, emit;

    always_comb begin
        accept     = i_pix_valid & in_ready_q;
        start      = accept & i_sof;
        take       = accept & (i_sof | (state_q != IDLE));
        pos_x      = start ? '0 : in_x_q;
        pos_y      = start ? '0 : in_y_q;
        last_x     = pos_x == X_MAX;
        emit       = 1'b0;
        state_d    = state_q;
        in_x_d     = in_x_q;
        in_y_d     = in_y_q;
        ctr_x_d    = ctr_x_q;
        ctr_y_d    = ctr_y_q;
        fill_d     = fill_q;
        err_d      = 1'b0;
        if (take) begin
            in_x_d = last_x ? '0 : pos_x + 1'b1;
            in_y_d = !last_x ? pos_y : (pos_y == Y_MAX) ? '0 : pos_y + 1'b1;
            err_d  = (i_sof & (state_q != IDLE)) | (i_eol != last_x);
        end
        // A sof always restarts the frame at (0,0), aborting any frame in progress.
        if (start) begin
            fill_d  = FW'(1);
            ctr_x_d = '0;
            ctr_y_d = '0;
            state_d = (LAG == 1) ? RUN : FILL;
        end else if (take && state_q == FILL) begin
            emit    = fill_q == F_LAG;
            fill_d  = emit ? fill_q : fill_q + 1'b1;
            state_d = emit ? RUN : FILL;
        end else if (take && state_q == RUN) begin
            emit    = 1'b1;
            state_d = (last_x && pos_y == Y_MAX) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            emit    = 1'b1;
            state_d = (ctr_x_q == X_MAX && ctr_y_q == Y_MAX) ? DONE : FLUSH;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        if (emit) begin
            ctr_x_d = (ctr_x_q == X_MAX) ? '0 : ctr_x_q + 1'b1;
            ctr_y_d = (ctr_x_q != X_MAX) ? ctr_y_q : (ctr_y_q == Y_MAX) ? '0 : ctr_y_q + 1'b1;
        end
        // Ready is registered from the next state so it stays low through reset.
        in_ready_d = (state_d == IDLE) | (state_d == FILL) | (state_d == RUN);
        vld_d      = emit;
        cx_d       = emit ? ctr_x_q : '0;
        cy_d       = emit ? ctr_y_q : '0;
        bdr_d      = emit & ((ctr_x_q < X_LO) | (ctr_x_q >= X_HI) | (ctr_y_q < Y_LO) | (ctr_y_q >= Y_HI));
        csof_d     = emit & (ctr_x_q == '0) & (ctr_y_q == '0);
        ceol_d     = emit & (ctr_x_q == X_MAX);
        ceof_d     = emit & (ctr_x_q == X_MAX) & (ctr_y_q == Y_MAX);
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            ctr_x_q    <= '0;
            ctr_y_q    <= '0;
            fill_q     <= '0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            bdr_q      <= 1'b0;
            csof_q     <= 1'b0;
            ceol_q     <= 1'b0;
            ceof_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            in_x_q     <= in_x_d;
            in_y_q     <= in_y_d;
            ctr_x_q    <= ctr_x_d;
            ctr_y_q    <= ctr_y_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            bdr_q      <= bdr_d;
            csof_q     <= csof_d;
            ceol_q     <= ceol_d;
            ceof_q     <= ceof_d;
        end
    end

    assign o_in_ready   = in_ready_q;
    assign o_flush_push = state_q == FLUSH;
    assign o_busy       = state_q != IDLE;
    assign o_err        = err_q;
    assign o_ctr_valid  = vld_q;
    assign o_ctr_x      = cx_q;
    assign o_ctr_y      = cy_q;
    assign o_ctr_border = bdr_q;
    assign o_ctr_sof    = csof_q;
    assign o_ctr_eol    = ceol_q;
    assign o_ctr_eof    = ceof_q;
endmodule

// File: tb/tb_median_window_sequencer.sv
// tb_median_window_sequencer: scoreboard bench; a raster-index model queues expected
// centres per accepted pixel, and a negedge monitor pops and compares them.
module tb_median_window_sequencer;
    localparam int W = 8, H = 6, K = 5, HALF = 2, LAG = 18, N = W * H;

    logic       i_clk = 1'b0, i_aresetn = 1'b0, i_pix_valid = 1'b0, i_sof = 1'b0, i_eol = 1'b0;
    logic       o_in_ready, o_flush_push, o_ctr_valid, o_ctr_border, o_ctr_sof, o_ctr_eol, o_ctr_eof, o_busy, o_err;
    logic [2:0] o_ctr_x, o_ctr_y;

    median_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut (
        .i_clk(i_clk), .i_aresetn(i_aresetn), .i_pix_valid(i_pix_valid), .i_sof(i_sof), .i_eol(i_eol),
        .o_in_ready(o_in_ready), .o_flush_push(o_flush_push), .o_ctr_valid(o_ctr_valid),
        .o_ctr_x(o_ctr_x), .o_ctr_y(o_ctr_y), .o_ctr_border(o_ctr_border), .o_ctr_sof(o_ctr_sof),
        .o_ctr_eol(o_ctr_eol), .o_ctr_eof(o_ctr_eof), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int         nvec = 0, nmis = 0;
    int         seen_ctr = 0, seen_flush = 0, seen_nb = 0, seen_err = 0;
    logic [9:0] sb[$];
    bit         exp_emit = 0, in_frame = 0, acc, rdy_s, busy_s, fl_s;
    int         k = 0;

    function automatic logic [9:0] centre(int i);
        int   x = i % W;
        int   y = i / W;
        logic b = (x < HALF) || (x >= W - HALF) || (y < HALF) || (y >= H - HALF);
        return {3'(x), 3'(y), b, i == 0, x == W - 1, i == N - 1};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Centre index = pixel index - LAG; the last pixel releases the LAG flushed centres.
    task automatic model_accept(logic s);
        exp_emit = 0;
        if (s) begin
            in_frame = 1;
            k = 0;
        end
        if (!in_frame) return;
        if (k >= LAG) begin
            sb.push_back(centre(k - LAG));
            exp_emit = 1;
        end
        if (k == N - 1) begin
            for (int i = N - LAG; i < N; i++) sb.push_back(centre(i));
            in_frame = 0;
        end
        k++;
    endtask

    task automatic cyc(logic v, logic s, logic e);
        i_pix_valid = v;
        i_sof = s;
        i_eol = e;
        @(negedge i_clk);
        rdy_s = o_in_ready;
        busy_s = o_busy;
        fl_s = o_flush_push;
        @(posedge i_clk);
        acc = v & rdy_s;
        if (acc) model_accept(s);
        else exp_emit = 0;
        #1;
    endtask

    task automatic send(logic s, logic e, bit stall);
        if (stall)
            for (int t = 0; t < 6 && $urandom_range(0, 1) == 1; t++) cyc(1'b0, 1'($urandom), 1'($urandom));
        acc = 0;
        for (int t = 0; t < 50 && !acc; t++) cyc(1'b1, s, e);
        check("accept_timeout", 32'(acc), 1);
    endtask

    task automatic feed(int restart_at, bit bad_eol, bit stall);
        for (int j = 0; j < N + restart_at; j++) begin
            int   pos = (restart_at > 0 && j >= restart_at) ? j - restart_at : j;
            logic s = pos == 0;
            logic e = (pos % W) == W - 1;
            if (bad_eol && j == 5) e = 1'b1;
            if (bad_eol && j == 7) e = 1'b0;
            send(s, e, stall);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (!busy_s && sb.size() == 0) break;
        end
        check("drained", 32'({busy_s, sb.size() != 0}), 0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(string name, int restart_at, bit bad_eol, bit stall, int errs);
        int c0 = seen_ctr, f0 = seen_flush, n0 = seen_nb, e0 = seen_err;
        feed(restart_at, bad_eol, stall);
        drain();
        check({name, "_centres"}, seen_ctr - c0, N + (restart_at > LAG ? restart_at - LAG : 0));
        check({name, "_flush"}, seen_flush - f0, LAG);
        check({name, "_nonborder"}, seen_nb - n0, 8);
        check({name, "_err"}, seen_err - e0, errs);
    endtask

    task automatic monitor();
        bit         fl_prev = 0;
        logic [9:0] e;
        forever begin
            @(negedge i_clk);
            if (!i_aresetn) begin
                check("reset_outs", 32'({o_in_ready, o_flush_push, o_ctr_valid, o_ctr_x, o_ctr_y, o_ctr_border,
                                         o_ctr_sof, o_ctr_eol, o_ctr_eof, o_busy, o_err}), 0);
                fl_prev = 0;
            end else begin
                check("ctr_valid", 32'(o_ctr_valid), 32'(exp_emit | fl_prev));
                if (o_ctr_valid) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("centre", 32'({o_ctr_x, o_ctr_y, o_ctr_border, o_ctr_sof, o_ctr_eol, o_ctr_eof}), 32'(e));
                        seen_ctr++;
                        if (!o_ctr_border) seen_nb++;
                    end
                end else begin
                    check("ctr_idle_zero", 32'({o_ctr_x, o_ctr_y, o_ctr_border, o_ctr_sof, o_ctr_eol, o_ctr_eof}), 0);
                end
                check("ready_in_flush", 32'(o_flush_push & o_in_ready), 0);
                if (o_flush_push) seen_flush++;
                if (o_err) seen_err++;
                fl_prev = o_flush_push;
            end
        end
    endtask

    initial begin
        int cnt;
        fork
            monitor();
        join_none
        i_pix_valid = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_aresetn = 1'b1;
        @(negedge i_clk);
        check("ready_at_release", 32'(o_in_ready), 0);
        @(negedge i_clk);
        check("ready_after_release", 32'(o_in_ready), 1);
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'($urandom));
        check("idle_drop_busy", 32'(busy_s), 0);
        frame("contig", 0, 0, 0, 0);
        frame("stall", 0, 0, 1, 0);
        frame("early_sof", 30, 0, 0, 1);
        frame("bad_eol", 0, 1, 0, 2);
        feed(0, 0, 0);
        cnt = 0;
        for (int t = 0; t < 40 && cnt < 4; t++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (fl_s) cnt++;
        end
        check("flush_before_reset", 32'(o_flush_push), 1);
        i_aresetn = 1'b0;
        sb.delete();
        in_frame = 0;
        exp_emit = 0;
        #1;
        check("midflush_reset_outs", 32'({o_flush_push, o_ctr_valid, o_in_ready, o_busy}), 0);
        repeat (2) @(posedge i_clk);
        #1 i_aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom));
            check("post_reset_busy", 32'(busy_s), 0);
        end
        frame("recover", 0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
